// File: rtl/mbc5_cfg_seq_pkg.sv
// Shared definitions for the MBC5 configuration sequencer: command op codes,
// FSM state encodings, mapper register addresses and mapper reset values.
package mbc5_cfg_seq_pkg;

   typedef enum logic [1:0] {
      OP_ROM_BANK = 2'b00,
      OP_RAM_BANK = 2'b01,
      OP_RAM_EN   = 2'b10,
      OP_RAM_DIS  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_DONE
   } state_e;

   // Mapper register selects, presented on cartridge address bits [15:12]
   localparam logic [3:0] REG_RAMG  = 4'h0;
   localparam logic [3:0] REG_ROMB0 = 4'h2;
   localparam logic [3:0] REG_ROMB1 = 4'h3;
   localparam logic [3:0] REG_RAMB  = 4'h4;

   localparam logic [7:0] RAMG_ON  = 8'h0A;
   localparam logic [7:0] RAMG_OFF = 8'h00;

   // Mapper power-on state, mirrored by the shadow registers
   localparam logic [8:0] ROM_BANK_RST = 9'd1;
   localparam logic [3:0] RAM_BANK_RST = 4'd0;
   localparam logic       RAM_EN_RST   = 1'b0;

   // One pending mapper register write
   typedef struct packed {
      logic [3:0] addr;
      logic [7:0] data;
   } wr_t;

   // Phase timer reload value: a phase of N cycles counts N-1 down to 0
   function automatic logic [3:0] cyc_load(input int cyc);
      return 4'(cyc - 1);
   endfunction

endpackage

// File: rtl/mbc5_cfg_seq_wr_timer.sv
// Loadable 4-bit down-counter with a zero flag; times SETUP/STROBE/HOLD phases.
module mbc5_cfg_seq_wr_timer (
   input  logic       phi,
   input  logic       rst,
   input  logic       i_load,
   input  logic [3:0] i_load_val,
   output logic       o_zero
);

   logic [3:0] r_count;

   // Reload on phase entry, otherwise count down and rest at zero
   always_ff @(posedge phi or negedge rst) begin
      if (!rst) begin
         r_count <= 4'd0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != 4'd0) begin
         r_count <= r_count - 4'd1;
      end
   end

   assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/mbc5_cfg_seq.sv
// MBC5 configuration sequencer: turns bank / RAM-enable commands into timed
// cartridge-bus register writes, skipping writes the shadow copy shows redundant.
module mbc5_cfg_seq
   import mbc5_cfg_seq_pkg::*;
#(
   parameter int SETUP_CYC   = 1,
   parameter int PULSE_CYC   = 2,
   parameter int HOLD_CYC    = 1,
   parameter int SHADOW_SKIP = 1
) (
   input  logic       phi,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [8:0] cmd_arg,
   output logic       bus_req,
   input  logic       bus_grant,
   output logic       mbc_oe,
   output logic [3:0] mbc_addr,
   output logic [7:0] mbc_data,
   output logic       mbc_wr,
   output logic       busy,
   output logic       done
);

   localparam logic [3:0] SETUP_LD = cyc_load(SETUP_CYC);
   localparam logic [3:0] PULSE_LD = cyc_load(PULSE_CYC);
   localparam logic [3:0] HOLD_LD  = cyc_load(HOLD_CYC);

   state_e     r_state;
   logic       r_cmd_ready;
   logic       r_bus_req;
   logic       r_mbc_oe;
   logic [3:0] r_mbc_addr;
   logic [7:0] r_mbc_data;
   logic       r_mbc_wr;
   logic       r_busy;
   logic       r_done;

   // Pending write list: slot 0 is the write in flight, slot 1 the one after it
   wr_t        r_q0;
   wr_t        r_q1;
   logic [1:0] r_q_cnt;

   // Mirror of the mapper registers
   logic [8:0] r_sh_rom;
   logic [3:0] r_sh_ram_bank;
   logic       r_sh_ram_en;

   logic       w_skip_en;
   wr_t        w_e0;
   wr_t        w_e1;
   logic       w_k0;
   logic       w_k1;
   wr_t        w_slot0;
   wr_t        w_slot1;
   logic [1:0] w_list_cnt;

   logic       w_tmr_load;
   logic [3:0] w_tmr_val;
   logic       w_tmr_zero;

   assign w_skip_en = (SHADOW_SKIP != 0);

   // Build the write list for the offered command, dropping writes that match the shadow
   always_comb begin
      w_e0 = '0;
      w_e1 = '0;
      w_k0 = 1'b0;
      w_k1 = 1'b0;
      case (op_e'(cmd_op))
         OP_ROM_BANK: begin
            w_e0 = '{addr: REG_ROMB0, data: cmd_arg[7:0]};
            w_k0 = !(w_skip_en && (cmd_arg[7:0] == r_sh_rom[7:0]));
            w_e1 = '{addr: REG_ROMB1, data: {7'b0, cmd_arg[8]}};
            w_k1 = !(w_skip_en && (cmd_arg[8] == r_sh_rom[8]));
         end
         OP_RAM_BANK: begin
            w_e0 = '{addr: REG_RAMB, data: {4'b0, cmd_arg[3:0]}};
            w_k0 = !(w_skip_en && (cmd_arg[3:0] == r_sh_ram_bank));
         end
         OP_RAM_EN: begin
            w_e0 = '{addr: REG_RAMG, data: RAMG_ON};
            w_k0 = !(w_skip_en && r_sh_ram_en);
         end
         OP_RAM_DIS: begin
            w_e0 = '{addr: REG_RAMG, data: RAMG_OFF};
            w_k0 = !(w_skip_en && !r_sh_ram_en);
         end
         default: begin
         end
      endcase
      // Compact so the first surviving write always lands in slot 0
      w_slot0    = w_k0 ? w_e0 : w_e1;
      w_slot1    = w_e1;
      w_list_cnt = {1'b0, w_k0} + {1'b0, w_k1};
   end

   // Reload the phase timer on every transition into SETUP, STROBE or HOLD
   always_comb begin
      w_tmr_load = 1'b0;
      w_tmr_val  = 4'd0;
      case (r_state)
         ST_REQ: begin
            if (bus_grant) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (bus_grant && w_tmr_zero) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = PULSE_LD;
            end
         end
         ST_STROBE: begin
            if (w_tmr_zero) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = HOLD_LD;
            end
         end
         ST_HOLD: begin
            if (w_tmr_zero && (r_q_cnt == 2'd2)) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = SETUP_LD;
            end
         end
         default: begin
         end
      endcase
   end

   mbc5_cfg_seq_wr_timer u_timer (
      .phi        (phi),
      .rst        (rst),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_zero     (w_tmr_zero)
   );

   // Sequencer FSM with registered bus outputs, write list and shadow updates
   always_ff @(posedge phi or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_cmd_ready   <= 1'b1;
         r_bus_req     <= 1'b0;
         r_mbc_oe      <= 1'b0;
         r_mbc_addr    <= 4'd0;
         r_mbc_data    <= 8'd0;
         r_mbc_wr      <= 1'b1;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_q0          <= '0;
         r_q1          <= '0;
         r_q_cnt       <= 2'd0;
         r_sh_rom      <= ROM_BANK_RST;
         r_sh_ram_bank <= RAM_BANK_RST;
         r_sh_ram_en   <= RAM_EN_RST;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_q0        <= w_slot0;
                  r_q1        <= w_slot1;
                  r_q_cnt     <= w_list_cnt;
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  if (w_list_cnt == 2'd0) begin
                     // Nothing to change on the mapper: complete without touching the bus
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state   <= ST_REQ;
                     r_bus_req <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               if (bus_grant) begin
                  r_state    <= ST_SETUP;
                  r_mbc_oe   <= 1'b1;
                  r_mbc_wr   <= 1'b1;
                  r_mbc_addr <= r_q0.addr;
                  r_mbc_data <= r_q0.data;
               end
            end
            ST_SETUP: begin
               if (!bus_grant) begin
                  // Lost the bus before the strobe: release drivers and retry this write
                  r_state  <= ST_REQ;
                  r_mbc_oe <= 1'b0;
               end else if (w_tmr_zero) begin
                  r_state  <= ST_STROBE;
                  r_mbc_wr <= 1'b0;
               end
            end
            ST_STROBE: begin
               if (w_tmr_zero) begin
                  r_state  <= ST_HOLD;
                  r_mbc_wr <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (w_tmr_zero) begin
                  case (r_q0.addr)
                     REG_ROMB0: r_sh_rom[7:0]  <= r_q0.data;
                     REG_ROMB1: r_sh_rom[8]    <= r_q0.data[0];
                     REG_RAMB:  r_sh_ram_bank  <= r_q0.data[3:0];
                     REG_RAMG:  r_sh_ram_en    <= (r_q0.data == RAMG_ON);
                     default: begin
                     end
                  endcase
                  if (r_q_cnt == 2'd2) begin
                     // Keep the bus and go straight into the next write
                     r_q0       <= r_q1;
                     r_q_cnt    <= 2'd1;
                     r_state    <= ST_SETUP;
                     r_mbc_addr <= r_q1.addr;
                     r_mbc_data <= r_q1.data;
                  end else begin
                     r_q_cnt   <= 2'd0;
                     r_state   <= ST_DONE;
                     r_bus_req <= 1'b0;
                     r_mbc_oe  <= 1'b0;
                     r_done    <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               r_state     <= ST_IDLE;
               r_cmd_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cmd_ready <= 1'b1;
               r_bus_req   <= 1'b0;
               r_mbc_oe    <= 1'b0;
               r_mbc_wr    <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign bus_req   = r_bus_req;
   assign mbc_oe    = r_mbc_oe;
   assign mbc_addr  = r_mbc_addr;
   assign mbc_data  = r_mbc_data;
   assign mbc_wr    = r_mbc_wr;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_mbc5_cfg_seq.sv
// Scoreboard bench for mbc5_cfg_seq: stimulus pushes expected writes/done events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_mbc5_cfg_seq;

   logic       phi = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [8:0] cmd_arg;
   logic       bus_req;
   logic       bus_grant;
   logic       mbc_oe;
   logic [3:0] mbc_addr;
   logic [7:0] mbc_data;
   logic       mbc_wr;
   logic       busy;
   logic       done;

   always #5 phi = ~phi;

   mbc5_cfg_seq dut (
      .phi       (phi),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_arg   (cmd_arg),
      .bus_req   (bus_req),
      .bus_grant (bus_grant),
      .mbc_oe    (mbc_oe),
      .mbc_addr  (mbc_addr),
      .mbc_data  (mbc_data),
      .mbc_wr    (mbc_wr),
      .busy      (busy),
      .done      (done)
   );

   typedef struct {
      bit         is_done;
      logic [3:0] addr;
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int   n_pass    = 0;
   int   n_total   = 0;
   int   wr_pulses = 0;
   int   req_wait  = 0;
   int   low_cnt   = 0;
   logic prev_wr   = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
      exp_t e;
      e.is_done = 1'b0;
      e.addr    = a;
      e.data    = d;
      exp_q.push_back(e);
   endtask

   task automatic push_done();
      exp_t e;
      e.is_done = 1'b1;
      e.addr    = 4'd0;
      e.data    = 8'd0;
      exp_q.push_back(e);
   endtask

   // Monitor: each wr rising edge is a mapper write; each done pulse ends a command
   always @(negedge phi) begin
      if (rst !== 1'b1) begin
         prev_wr = 1'b1;
         low_cnt = 0;
      end else begin
         if (mbc_wr === 1'b0) low_cnt++;
         if (prev_wr === 1'b0 && mbc_wr === 1'b1) begin
            wr_pulses++;
            $display("[%0t] write addr=%h data=%h strobe=%0d", $time, mbc_addr, mbc_data, low_cnt);
            chk("strobe width", low_cnt, 2);
            chk("oe during write", mbc_oe, 1);
            chk("sb has entry for write", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               chk("write expected not done", mon_e.is_done, 0);
               chk("write addr", mbc_addr, mon_e.addr);
               chk("write data", mbc_data, mon_e.data);
            end
            low_cnt = 0;
         end
         if (done === 1'b1) begin
            $display("[%0t] done", $time);
            chk("sb has entry for done", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               chk("done expected", mon_e.is_done, 1);
            end
         end
         if (bus_req === 1'b1 && mbc_oe === 1'b0) req_wait++;
         prev_wr = mbc_wr;
      end
   end

   task automatic send(input logic [1:0] op, input logic [8:0] arg);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge phi);
         if (cmd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      chk("cmd_ready before send", ok, 1);
      cmd_op    = op;
      cmd_arg   = arg;
      cmd_valid = 1'b1;
      @(posedge phi);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_done(output int k);
      k = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge phi);
         if (done === 1'b1) begin
            k = i;
            break;
         end
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge phi);
         if (cmd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      chk("return to idle", ok, 1);
   endtask

   task automatic do_reset();
      @(negedge phi);
      #2 rst = 1'b0;
      repeat (2) @(negedge phi);
      #2 rst = 1'b1;
   endtask

   int k;

   initial begin
      rst       = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_arg   = 9'd0;
      bus_grant = 1'b0;

      // Test 1: reset values, then ROM bank 1A5 with grant held high
      repeat (3) @(negedge phi);
      chk("rst cmd_ready", cmd_ready, 1);
      chk("rst bus_req", bus_req, 0);
      chk("rst mbc_oe", mbc_oe, 0);
      chk("rst mbc_wr", mbc_wr, 1);
      chk("rst mbc_addr", mbc_addr, 0);
      chk("rst mbc_data", mbc_data, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst shadow rom", dut.r_sh_rom, 9'd1);
      #2 rst = 1'b1;
      bus_grant = 1'b1;
      wr_pulses = 0;
      push_wr(4'h2, 8'hA5);
      push_wr(4'h3, 8'h01);
      push_done();
      send(2'b00, 9'h1A5);
      chk("t1 busy after accept", busy, 1);
      wait_done(k);
      chk("t1 done latency", k, 10);
      wait_idle();
      chk("t1 wr pulses", wr_pulses, 2);
      chk("t1 shadow rom", dut.r_sh_rom, 9'h1A5);

      // Test 2: ROM bank 001 straight after reset is fully skipped
      do_reset();
      wr_pulses = 0;
      req_wait  = 0;
      push_done();
      send(2'b00, 9'h001);
      chk("t2 bus_req after accept", bus_req, 0);
      wait_done(k);
      chk("t2 done latency", k, 1);
      wait_idle();
      chk("t2 wr pulses", wr_pulses, 0);
      chk("t2 bus_req cycles", req_wait, 0);

      // Test 3: RAM enable with grant held off for 5 cycles
      bus_grant = 1'b0;
      req_wait  = 0;
      wr_pulses = 0;
      push_wr(4'h0, 8'h0A);
      push_done();
      send(2'b10, 9'h000);
      repeat (5) @(negedge phi);
      chk("t3 waiting oe off", mbc_oe, 0);
      bus_grant = 1'b1;
      wait_done(k);
      chk("t3 done seen", k != 0, 1);
      wait_idle();
      chk("t3 bus_req without oe cycles", req_wait, 5);
      chk("t3 wr pulses", wr_pulses, 1);
      chk("t3 shadow ram_en", dut.r_sh_ram_en, 1);

      // Test 4: grant dropped in SETUP of the (3,xx) write; only that write retries
      req_wait  = 0;
      wr_pulses = 0;
      push_wr(4'h2, 8'h55);
      push_wr(4'h3, 8'h01);
      push_done();
      send(2'b00, 9'h155);
      repeat (6) @(negedge phi);
      chk("t4 in second setup", mbc_addr, 4'h3);
      bus_grant = 1'b0;
      repeat (2) @(negedge phi);
      bus_grant = 1'b1;
      wait_done(k);
      chk("t4 done latency after regrant", k, 5);
      wait_idle();
      chk("t4 wr pulses", wr_pulses, 2);
      chk("t4 bus_req without oe cycles", req_wait, 3);
      chk("t4 shadow rom", dut.r_sh_rom, 9'h155);

      // Test 5: reset asserted during STROBE
      wr_pulses = 0;
      send(2'b01, 9'h003);
      repeat (3) @(negedge phi);
      chk("t5 strobe active", mbc_wr, 0);
      #2 rst = 1'b0;
      @(negedge phi);
      chk("t5 mbc_wr", mbc_wr, 1);
      chk("t5 mbc_oe", mbc_oe, 0);
      chk("t5 bus_req", bus_req, 0);
      chk("t5 cmd_ready", cmd_ready, 1);
      chk("t5 shadow rom", dut.r_sh_rom, 9'd1);
      chk("t5 shadow ram_bank", dut.r_sh_ram_bank, 4'd0);
      chk("t5 shadow ram_en", dut.r_sh_ram_en, 0);
      #2 rst = 1'b1;
      chk("t5 wr pulses", wr_pulses, 0);

      // Test 6: RAM bank F twice; second one is skipped but still completes
      wr_pulses = 0;
      push_wr(4'h4, 8'h0F);
      push_done();
      send(2'b01, 9'h00F);
      wait_done(k);
      chk("t6 first done latency", k, 6);
      wait_idle();
      push_done();
      send(2'b01, 9'h00F);
      wait_done(k);
      chk("t6 second done latency", k, 1);
      wait_idle();
      chk("t6 wr pulses", wr_pulses, 1);
      chk("t6 shadow ram_bank", dut.r_sh_ram_bank, 4'hF);

      repeat (3) @(negedge phi);
      chk("scoreboard drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
